// File: rtl/ul_pkg.sv
// Shared definitions for the ul4 logic unit and its arbitrated wrapper.
package ul_pkg;

  localparam int UL_W = 4;

  localparam logic [1:0] UL_AND  = 2'b00;
  localparam logic [1:0] UL_OR   = 2'b01;
  localparam logic [1:0] UL_XOR  = 2'b10;
  localparam logic [1:0] UL_NOTA = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  // First requester at or after ptr wins; nothing is granted while en is low.
  always_comb begin : search
    logic          found;
    logic [IW-1:0] idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/ul4.sv
// ul4: 4-bit bitwise logic unit, out = f(a, b, s).
module ul4
  import ul_pkg::*;
(
  input  logic [UL_W-1:0] a,
  input  logic [UL_W-1:0] b,
  input  logic [1:0]      s,
  output logic [UL_W-1:0] out
);

  // Select the bitwise operation; NOT A deliberately ignores b.
  always_comb begin
    out = '0;
    case (s)
      UL_AND:  out = a & b;
      UL_OR:   out = a | b;
      UL_XOR:  out = a ^ b;
      UL_NOTA: out = ~a;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/ul4_arbiter.sv
// ul4_arbiter: shares one ul4 among NREQ requesters through a round-robin
// arbiter and a one-entry result register drained over a valid/ready port.
// Optional macro UL4_ARB_STATS_EN adds a saturating response counter op_count.
module ul4_arbiter
  import ul_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  input  logic [2*NREQ-1:0]    req_s,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [UL_W-1:0]      resp_out,
  output logic [ID_W-1:0]      resp_id
`ifdef UL4_ARB_STATS_EN
  ,output logic [15:0]         op_count
`endif
);

  slot_state_t     state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] next_ptr;
  logic [NREQ-1:0] grant;
  logic            slot_free;
  logic            accept;
  logic [UL_W-1:0] sel_a;
  logic [UL_W-1:0] sel_b;
  logic [1:0]      sel_s;
  logic [UL_W-1:0] result;

  assign resp_valid = (state == FULL);
  assign slot_free  = !resp_valid || resp_ready;

  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .en       (slot_free && rst_n),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign next_ptr  = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Route the granted requester's operands into the single shared ul4.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*UL_W +: UL_W];
        sel_b = req_b[i*UL_W +: UL_W];
        sel_s = req_s[i*2 +: 2];
      end
    end
  end

  ul4 u_ul4 (
    .a   (sel_a),
    .b   (sel_b),
    .s   (sel_s),
    .out (result)
  );

  // Result slot FSM: an accept always overwrites, a drain without accept empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      resp_out <= '0;
      resp_id  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        resp_out <= result;
        resp_id  <= grant_id;
        rr_ptr   <= next_ptr;
      end
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (!accept && resp_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef UL4_ARB_STATS_EN
  // Count response handshakes, sticking at the top value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (resp_valid && resp_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ul4_arbiter.sv
// Testbench for ul4_arbiter: directed vectors with a response scoreboard.
module tb_ul4_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_s;
  logic              resp_valid;
  logic              resp_ready;
  logic [3:0]        resp_out;
  logic [ID_W-1:0]   resp_id;
`ifdef UL4_ARB_STATS_EN
  logic [15:0]       op_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [ID_W+3:0] sbq[$];
  logic [ID_W+3:0] sbExp;

  logic [1:0] opS   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] opExp [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
  int         gOrder[6] = '{0, 1, 2, 3, 0, 1};

  ul4_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_id    (resp_id)
`ifdef UL4_ARB_STATS_EN
    ,.op_count  (op_count)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] s);
    req_valid[i]     = v;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_s[2*i +: 2]  = s;
  endtask

  task automatic expectResp(input logic [ID_W-1:0] id, input logic [3:0] out);
    sbq.push_back({id, out});
  endtask

  // Monitor: every response handshake pops one expected {id,out} entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got id %0d out %b, expected no response", resp_id, resp_out);
      end else begin
        sbExp = sbq.pop_front();
        if ({resp_id, resp_out} !== sbExp) begin
          errors++;
          $display("[TB] FAIL sb_resp: got id %0d out %b, expected id %0d out %b",
                   resp_id, resp_out, sbExp[ID_W+3:4], sbExp[3:0]);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_s      = '0;

    $display("[TB] reset values");
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 4'b1100, 4'b1010, 2'b00);
    repeat (3) tick;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_out", 32'(resp_out), 32'h0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick;
    checkOutput("idle_resp_valid", 32'(resp_valid), 32'h0);

    $display("[TB] single requests, all operations");
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, 4'b1100, 4'b1010, opS[k]);
      expectResp(2'd0, opExp[k]);
      tick;
      checkOutput("op_valid", 32'(resp_valid), 32'h1);
      checkOutput("op_out", 32'(resp_out), 32'(opExp[k]));
      checkOutput("op_id", 32'(resp_id), 32'h0);
    end
    applyStimulus(0, 1'b0, 4'b0000, 4'b0000, 2'b00);
    tick;
    checkOutput("drain_valid", 32'(resp_valid), 32'h0);

    $display("[TB] fairness");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 4'(i + 1), 4'b0000, 2'b10);
    #1;
    for (int c = 0; c < 6; c++) begin
      checkOutput("fair_grant", 32'(req_ready), 32'(4'b0001 << gOrder[c]));
      expectResp(ID_W'(gOrder[c]), 4'(gOrder[c] + 1));
      tick;
    end

    $display("[TB] backpressure");
    resp_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_ready", 32'(req_ready), 32'h0);
      checkOutput("bp_valid", 32'(resp_valid), 32'h1);
      checkOutput("bp_out", 32'(resp_out), 32'h2);
      checkOutput("bp_id", 32'(resp_id), 32'h1);
      tick;
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("bp_release_grant", 32'(req_ready), 32'h4);
    expectResp(2'd2, 4'd3);
    tick;
    checkOutput("no_bubble_valid", 32'(resp_valid), 32'h1);
    checkOutput("no_bubble_id", 32'(resp_id), 32'h2);
    checkOutput("no_bubble_out", 32'(resp_out), 32'h3);

    $display("[TB] mid-operation reset");
    resp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    checkOutput("mid_rst_valid", 32'(resp_valid), 32'h0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
    tick;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    checkOutput("restart_grant", 32'(req_ready), 32'h1);
    expectResp(2'd0, 4'd1);
    tick;
    req_valid = '0;
    tick;
    tick;
    checkOutput("restart_drained", 32'(resp_valid), 32'h0);

`ifdef UL4_ARB_STATS_EN
    $display("[TB] statistics counter");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("cnt_reset", 32'(op_count), 32'h0);
    applyStimulus(0, 1'b1, 4'b1100, 4'b1010, 2'b00);
    for (int c = 0; c < 10; c++) begin
      expectResp(2'd0, 4'b1000);
      tick;
    end
    req_valid = '0;
    tick;
    checkOutput("cnt_ten", 32'(op_count), 32'd10);
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    applyStimulus(0, 1'b1, 4'b1100, 4'b1010, 2'b00);
    expectResp(2'd0, 4'b1000);
    tick;
    req_valid = '0;
    tick;
    checkOutput("cnt_saturate", 32'(op_count), 32'hFFFF);
`endif

    #1;
    checkOutput("sb_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ul4_arbiter.md
Name: ul4_arbiter

Overview:
- Shares one 4-bit logic unit (the existing ul4 datapath: Out = f(A, B, S)) among NREQ requesters.
- Each requester presents operands A, B and operation S over a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and drives the shared ul4.
- The result is captured with the requester's ID in a one-entry output register, which is drained by a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, $clog2(NREQ), width of the requester ID (derived; do not override).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester request valid.
- req_ready, output, NREQ, per-requester accept; at most one bit high (one-hot or zero).
- req_a, input, 4*NREQ, packed A operands; requester i uses bits [4i+3:4i].
- req_b, input, 4*NREQ, packed B operands, same packing.
- req_s, input, 2*NREQ, packed operation selects; requester i uses bits [2i+1:2i].
- resp_valid, output, 1, result register holds a result.
- resp_ready, input, 1, consumer accepts the result.
- resp_out, output, 4, result value.
- resp_id, output, ID_W, index of the requester that produced resp_out.

Behaviour:
- Reset (async assert, sync deassert externally guaranteed):
  - resp_valid=0, resp_out=0, resp_id=0, rr_ptr=0.
  - req_ready is all-zero while rst_n is low.
- Operation encoding of ul4, applied bitwise:
  - S=00: A AND B.
  - S=01: A OR B.
  - S=10: A XOR B.
  - S=11: NOT A; B is ignored.
- Slot-free condition: slot_free = !resp_valid || resp_ready.
- Arbitration (combinational):
  - When slot_free=1 and any req_valid is set, grant the first requester with valid set, searching from rr_ptr upward with modulo-NREQ wrap.
  - req_ready[grant]=1; every other req_ready bit is 0.
  - When slot_free=0, req_ready is all-zero.
- Accept: a transfer occurs when req_valid[i] && req_ready[i]. The granted A/B/S are muxed into the single ul4 instance in the same cycle.
- Latency: a request accepted at edge N produces resp_valid=1 with resp_out and resp_id valid after edge N. Result latency is therefore 1 cycle.
- Result register update:
  - On accept: load resp_out, resp_id and set resp_valid=1.
  - On resp_ready && !accept: clear resp_valid; resp_out and resp_id hold their last values.
  - Simultaneous response drain and new accept: the register is overwritten, and resp_valid stays 1.
- Throughput: 1 op/cycle while resp_ready is held high.
- Pointer: after an accept from requester g, rr_ptr = (g+1) mod NREQ. With no accept, rr_ptr holds.
- Backpressure: while resp_valid=1 and resp_ready=0, all outputs are stable, no request is accepted, and rr_ptr holds.
- Requester protocol: once req_valid is raised, a requester holds req_valid and its operands stable until accepted. The block does not check this.
- Reset mid-operation: the pending result is discarded with no response, and rr_ptr returns to 0.
- State machine (2 states):
  - EMPTY (resp_valid=0) goes to FULL on accept.
  - FULL goes to EMPTY on resp_ready with no accept.
  - FULL stays FULL on accept, or on no resp_ready.

Optional Feature:
- Macro: UL4_ARB_STATS_EN.
- When defined, adds output port op_count[15:0]:
  - Increments on each response handshake (resp_valid && resp_ready).
  - Saturates at 16'hFFFF.
  - Resets to 0.
- When undefined, the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ul_pkg:
  - Op-code localparams UL_AND=2'b00, UL_OR=2'b01, UL_XOR=2'b10, UL_NOTA=2'b11.
  - Data width constant UL_W=4.
- Sub-module rr_arbiter #(N): inputs req[N-1:0], ptr, en; outputs one-hot grant and encoded grant_id. Purely combinational.
- ul4 is reused unmodified as the datapath instance.

Test Plan:
1. Reset value check: hold rst_n=0 with all req_valid=1 -> req_ready=0, resp_valid=0, resp_out=0. Release reset -> requester 0 is granted first.
2. Single request: req0 with A=4'b1100, B=4'b1010, S=00, resp_ready=1.
   - One cycle later: resp_out=4'b1000, resp_id=0.
   - Repeat with S=01 -> 4'b1110; S=10 -> 4'b0110; S=11 -> 4'b0011.
3. Fairness: all four requesters valid continuously, resp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, with resp_id following one cycle later.
4. Backpressure: resp_ready=0 for 5 cycles after the first result.
   - resp_out and resp_id are held and req_ready=0 throughout.
   - On resp_ready=1, the next request is accepted in that same cycle, so resp_valid stays 1 with no bubble.
5. Mid-operation reset: pulse rst_n low while resp_valid=1 -> resp_valid drops immediately (asynchronously), no response is emitted, and arbitration restarts at requester 0.
6. With UL4_ARB_STATS_EN: run 10 response handshakes -> op_count=10. Force the count to 16'hFFFF and perform one more handshake -> op_count stays 16'hFFFF.
